// File: rtl/i_cache_if.sv
// Fetch-side and fill-side buses of the instruction cache, bundled for the cache (slave)
// and for whatever drives the CPU fetch and backs physical memory (master).
interface i_cache_if;
  logic [15:0]  mem_address;
  logic         mem_read;
  logic [15:0]  mem_rdata;
  logic         mem_resp;
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  modport slave (
    input  mem_address, mem_read, pmem_rdata, pmem_resp,
    output mem_rdata, mem_resp, pmem_address, pmem_read
  );

  modport master (
    output mem_address, mem_read, pmem_rdata, pmem_resp,
    input  mem_rdata, mem_resp, pmem_address, pmem_read
  );
endinterface

// File: rtl/i_cache.sv
// Read-only 2-way set-associative instruction cache; hit responds 1 cycle after the fetch is sampled,
// a miss fills a 128-bit line (pmem_read held until pmem_resp) and then re-looks-up as a hit.
module i_cache #(
  parameter int NUM_SETS = 8
) (
  input logic      clk,
  input logic      reset,
  i_cache_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 12 - IDX_W;

  typedef enum logic {IDLE, FILL} state_t;

  state_t             state_q, state_d;
  logic               mem_resp_q, mem_resp_d;
  logic [15:0]        mem_rdata_q, mem_rdata_d;
  logic               pmem_read_q, pmem_read_d;
  logic [15:0]        pmem_address_q, pmem_address_d;
  logic [1:0]         valid_q [NUM_SETS];
  logic [1:0]         valid_d [NUM_SETS];
  logic [TAG_W-1:0]   tag_q   [2][NUM_SETS];
  logic [TAG_W-1:0]   tag_d   [2][NUM_SETS];
  logic [127:0]       line_q  [2][NUM_SETS];
  logic [127:0]       line_d  [2][NUM_SETS];
  logic [NUM_SETS-1:0] lru_q, lru_d;

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [2:0]       req_word;
  logic             hit0, hit1, hit_way;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic             victim;
  logic             unused_addr_bit;

  assign req_idx         = bus.mem_address[3+IDX_W:4];
  assign req_tag         = bus.mem_address[15:4+IDX_W];
  assign req_word        = bus.mem_address[3:1];
  assign unused_addr_bit = bus.mem_address[0];

  assign hit0    = valid_q[req_idx][0] && (tag_q[0][req_idx] == req_tag);
  assign hit1    = valid_q[req_idx][1] && (tag_q[1][req_idx] == req_tag);
  assign hit_way = hit1;

  // Fill target comes from the latched address so PC changes during FILL cannot redirect it.
  assign fill_idx = pmem_address_q[3+IDX_W:4];
  assign fill_tag = pmem_address_q[15:4+IDX_W];
  assign victim   = !valid_q[fill_idx][0] ? 1'b0 :
                    !valid_q[fill_idx][1] ? 1'b1 : lru_q[fill_idx];

  always_comb begin
    state_d        = state_q;
    mem_resp_d     = 1'b0;
    mem_rdata_d    = mem_rdata_q;
    pmem_read_d    = pmem_read_q;
    pmem_address_d = pmem_address_q;
    valid_d        = valid_q;
    tag_d          = tag_q;
    line_d         = line_q;
    lru_d          = lru_q;
    case (state_q)
      IDLE: begin
        // Skipping lookup while mem_resp is high keeps responses from going back-to-back.
        if (bus.mem_read && !mem_resp_q) begin
          if (hit0 || hit1) begin
            mem_resp_d       = 1'b1;
            mem_rdata_d      = line_q[hit_way][req_idx][{req_word, 4'b0} +: 16];
            lru_d[req_idx]   = ~hit_way;
          end else begin
            pmem_address_d = {req_tag, req_idx, 4'b0};
            pmem_read_d    = 1'b1;
            state_d        = FILL;
          end
        end
      end
      FILL: begin
        if (bus.pmem_resp) begin
          valid_d[fill_idx][victim] = 1'b1;
          tag_d[victim][fill_idx]   = fill_tag;
          line_d[victim][fill_idx]  = bus.pmem_rdata;
          lru_d[fill_idx]           = ~victim;
          pmem_read_d               = 1'b0;
          state_d                   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      mem_resp_q     <= 1'b0;
      mem_rdata_q    <= '0;
      pmem_read_q    <= 1'b0;
      pmem_address_q <= '0;
      lru_q          <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < 2; w++) begin
          tag_q[w][s]  <= '0;
          line_q[w][s] <= '0;
        end
      end
    end else begin
      state_q        <= state_d;
      mem_resp_q     <= mem_resp_d;
      mem_rdata_q    <= mem_rdata_d;
      pmem_read_q    <= pmem_read_d;
      pmem_address_q <= pmem_address_d;
      lru_q          <= lru_d;
      valid_q        <= valid_d;
      tag_q          <= tag_d;
      line_q         <= line_d;
    end
  end

  assign bus.mem_resp     = mem_resp_q;
  assign bus.mem_rdata    = mem_rdata_q;
  assign bus.pmem_read    = pmem_read_q;
  assign bus.pmem_address = pmem_address_q;
endmodule

// File: tb/tb_i_cache.sv
// Directed bench for i_cache: cold miss, hits, LRU eviction, dropped fetch, reset mid-fill, IF streaming.
module tb_i_cache;
  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  i_cache_if bus();

  i_cache #(.NUM_SETS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory image: word i of the line at byte address a is 0x1000 + a + i.
  function automatic logic [127:0] mk_line(input logic [15:0] a);
    logic [127:0] l;
    for (int i = 0; i < 8; i++) l[16*i +: 16] = 16'h1000 + a + 16'(i);
    return l;
  endfunction

  task automatic read_hit(input string tag, input logic [15:0] addr, input logic [15:0] exp);
    bus.mem_read    = 1'b1;
    bus.mem_address = addr;
    tick();
    check({tag, "_resp"}, 32'(bus.mem_resp), 32'd1);
    check({tag, "_rdata"}, 32'(bus.mem_rdata), 32'(exp));
    check({tag, "_nofill"}, 32'(bus.pmem_read), 32'd0);
    bus.mem_read = 1'b0;
    tick();
    check({tag, "_resp_clr"}, 32'(bus.mem_resp), 32'd0);
  endtask

  task automatic read_miss(input string tag, input logic [15:0] addr, input logic [15:0] exp);
    logic [15:0] line_a;
    line_a          = addr & 16'hFFF0;
    bus.mem_read    = 1'b1;
    bus.mem_address = addr;
    tick();
    check({tag, "_pread"}, 32'(bus.pmem_read), 32'd1);
    check({tag, "_paddr"}, 32'(bus.pmem_address), 32'(line_a));
    tick();
    check({tag, "_pread_hold"}, 32'(bus.pmem_read), 32'd1);
    bus.pmem_rdata = mk_line(line_a);
    bus.pmem_resp  = 1'b1;
    tick();
    bus.pmem_resp = 1'b0;
    check({tag, "_pread_drop"}, 32'(bus.pmem_read), 32'd0);
    check({tag, "_noresp_yet"}, 32'(bus.mem_resp), 32'd0);
    tick();
    check({tag, "_resp"}, 32'(bus.mem_resp), 32'd1);
    check({tag, "_rdata"}, 32'(bus.mem_rdata), 32'(exp));
    bus.mem_read = 1'b0;
    tick();
    check({tag, "_resp_clr"}, 32'(bus.mem_resp), 32'd0);
  endtask

  initial begin
    logic [15:0] pc;
    logic [15:0] fill_addr [2];
    int          resp_cnt, fills, wait_cnt, b2b;
    logic        prev;

    reset           = 1'b1;
    bus.mem_read    = 1'b0;
    bus.mem_address = '0;
    bus.pmem_rdata  = '0;
    bus.pmem_resp   = 1'b0;
    tick();
    tick();
    check("rst_resp", 32'(bus.mem_resp), 32'd0);
    check("rst_rdata", 32'(bus.mem_rdata), 32'd0);
    check("rst_pread", 32'(bus.pmem_read), 32'd0);
    check("rst_paddr", 32'(bus.pmem_address), 32'd0);
    reset = 1'b0;
    tick();

    // 1: cold miss, 2: hits in the same line
    read_miss("t1", 16'h0006, 16'h1003);
    read_hit("t2a", 16'h000E, 16'h1007);
    read_hit("t2b", 16'h000F, 16'h1007);

    // 3: two lines in set 0, touch 0x0000 so 0x0080 becomes the victim of 0x0100
    read_miss("t3_fill80", 16'h0080, 16'h1080);
    read_hit("t3_hit0", 16'h0000, 16'h1000);
    read_miss("t3_fill100", 16'h0102, 16'h1101);
    read_hit("t3_still0", 16'h0000, 16'h1000);
    read_miss("t3_evicted80", 16'h0080, 16'h1080);

    // 4: fetch withdrawn during FILL; line still installed
    bus.mem_read    = 1'b1;
    bus.mem_address = 16'h0204;
    tick();
    check("t4_pread", 32'(bus.pmem_read), 32'd1);
    check("t4_paddr", 32'(bus.pmem_address), 32'h0200);
    tick();
    tick();
    bus.mem_read = 1'b0;
    tick();
    check("t4_pread_hold", 32'(bus.pmem_read), 32'd1);
    bus.pmem_rdata = mk_line(16'h0200);
    bus.pmem_resp  = 1'b1;
    tick();
    bus.pmem_resp = 1'b0;
    check("t4_pread_drop", 32'(bus.pmem_read), 32'd0);
    check("t4_noresp_a", 32'(bus.mem_resp), 32'd0);
    tick();
    check("t4_noresp_b", 32'(bus.mem_resp), 32'd0);
    read_hit("t4_hit", 16'h0204, 16'h1202);

    // 5: reset mid-FILL, then a stale pmem_resp
    bus.mem_read    = 1'b1;
    bus.mem_address = 16'h0300;
    tick();
    check("t5_pread", 32'(bus.pmem_read), 32'd1);
    reset        = 1'b1;
    bus.mem_read = 1'b0;
    #1;
    check("t5_rst_pread", 32'(bus.pmem_read), 32'd0);
    check("t5_rst_resp", 32'(bus.mem_resp), 32'd0);
    tick();
    reset          = 1'b0;
    bus.pmem_rdata = mk_line(16'h0300);
    bus.pmem_resp  = 1'b1;
    tick();
    bus.pmem_resp = 1'b0;
    check("t5_stale_pread", 32'(bus.pmem_read), 32'd0);
    check("t5_stale_resp", 32'(bus.mem_resp), 32'd0);
    read_miss("t5_remiss", 16'h0300, 16'h1300);
    read_miss("t5_cleared", 16'h0000, 16'h1000);

    // 6: IF-style streaming fetch, read = ~resp, memory answers 2 cycles into each fill
    reset = 1'b1;
    tick();
    reset           = 1'b0;
    pc              = 16'h0000;
    resp_cnt        = 0;
    fills           = 0;
    wait_cnt        = 0;
    b2b             = 0;
    prev            = 1'b0;
    fill_addr[0]    = 16'hFFFF;
    fill_addr[1]    = 16'hFFFF;
    bus.mem_read    = 1'b1;
    bus.mem_address = pc;
    for (int cyc = 0; cyc < 400 && resp_cnt < 16; cyc++) begin
      tick();
      if (bus.mem_resp) begin
        check("t6_rdata", 32'(bus.mem_rdata), 32'(16'h1000 + (pc & 16'hFFF0) + 16'(pc[3:1])));
        resp_cnt++;
        pc = pc + 16'd2;
      end
      if (bus.mem_resp && prev) b2b++;
      prev            = bus.mem_resp;
      bus.mem_read    = !bus.mem_resp && (resp_cnt < 16);
      bus.mem_address = pc;
      if (bus.pmem_resp) begin
        bus.pmem_resp = 1'b0;
      end else if (bus.pmem_read) begin
        wait_cnt++;
        if (wait_cnt == 2) begin
          if (fills < 2) fill_addr[fills] = bus.pmem_address;
          fills++;
          bus.pmem_rdata = mk_line(bus.pmem_address);
          bus.pmem_resp  = 1'b1;
          wait_cnt       = 0;
        end
      end
    end
    bus.mem_read  = 1'b0;
    bus.pmem_resp = 1'b0;
    check("t6_resp_count", 32'(resp_cnt), 32'd16);
    check("t6_back_to_back", 32'(b2b), 32'd0);
    check("t6_fills", 32'(fills), 32'd2);
    check("t6_fill0_addr", 32'(fill_addr[0]), 32'h0000);
    check("t6_fill1_addr", 32'(fill_addr[1]), 32'h0010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
